serial_to_parallel: RTL and testbench
=====================================

Name: serial_to_parallel

Overview:
- Downstream companion to the parallel-to-serial converter.
- Samples a framed serial bit stream, one bit per clock, and assembles DATA_SIZE bits into a parallel word.
- Holds the word with a valid/ack handshake for the consuming logic.
- Flags short frames and overruns. Sits between a serial link (or loopback from the serializer) and a parallel register or FIFO interface.

Parameters:
- DATA_SIZE, 8, word width in bits; legal range >= 2.
- MSB_FIRST, 1, 1: first received bit lands in data_o[DATA_SIZE-1]; 0: first received bit lands in data_o[0].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_i  input  1  serial data bit, sampled on clk when frame_i=1.
- frame_i  input  1  frame qualifier; high for the bits of one word.
- ack_i  input  1  consumer accepts data_o; effective only while valid_o=1.
- data_o  output  DATA_SIZE  last completed word; stable while valid_o=1.
- valid_o  output  1  completed word pending.
- busy_o  output  1  frame reception in progress (state RECV).
- frame_err_o  output  1  one-cycle pulse when a frame ends early.
- overrun_o  output  1  sticky; a word committed while the previous one was unacknowledged.

Behaviour:
- Reset (async, active-high): state=IDLE, bit counter=0, shift register=0, data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
- Counter width: $clog2(DATA_SIZE+1). No wrap is possible; the counter clears on every frame start.
- State IDLE:
  - frame_i=1 samples serial_i as bit 0; counter<=1; go to RECV.
  - The first data bit is present in the same cycle frame_i rises.
- State RECV:
  - busy_o=1.
  - Each cycle with frame_i=1: shift in serial_i and increment the counter. MSB_FIRST=1 shifts left with LSB insertion; MSB_FIRST=0 shifts right with MSB insertion.
  - When the bit being sampled is bit DATA_SIZE-1 (counter==DATA_SIZE-1 and frame_i=1), commit:
    - data_o<=assembled word including the current bit.
    - valid_o<=1.
    - Go to WAIT_END.
  - Latency: data_o and valid_o update on the clock edge that samples the last bit.
  - frame_i=0 before commit: discard the partial word, pulse frame_err_o for exactly one cycle, go to IDLE. data_o and valid_o are untouched.
- State WAIT_END:
  - Bits arriving with frame_i=1 are ignored.
  - frame_i=0 goes to IDLE. A new frame therefore requires frame_i to be low for at least one cycle.
- Handshake:
  - ack_i=1 while valid_o=1 clears valid_o next cycle.
  - ack_i while valid_o=0 has no effect.
- Commit while valid_o=1:
  - With ack_i=0 in the same cycle: data_o is overwritten with the new word, valid_o stays 1, overrun_o<=1.
  - With ack_i=1 in the same cycle: the new word is taken, valid_o stays 1, overrun_o is unchanged.
- overrun_o clears only on rst.
- Reset mid-frame: all state clears immediately and the partial word is lost. After release, a frame_i already high is treated as a new frame start, bit 0.

Optional Feature:
- Macro: S2P_PARITY_EN.
- Defined:
  - Frame length is DATA_SIZE+1 bits; the extra final bit is an even-parity bit over the data bits.
  - Commit occurs on the parity bit.
  - Adds output parity_err_o (1 bit), updated at each commit: 1 if XOR of data bits and parity bit is 1, else 0. Reset value 0.
  - The word is committed even on a parity error.
  - A frame ending before the parity bit counts as a short frame.
- Not defined: no parity bit, no parity_err_o port; behaviour exactly as above.

Decomposition:
- Shared package s2p_pkg:
  - State enum constants ST_IDLE=2'd0, ST_RECV=2'd1, ST_WAIT_END=2'd2.
  - Counter-width function.
- One natural sub-module: s2p_shift_reg (parameterised shift register with MSB_FIRST direction and clear/load controls).
- FSM, counter and handshake stay in the top.

Test Plan:
- After reset, DATA_SIZE=8, MSB_FIRST=1: frame_i high 8 cycles, bits 1,0,1,0,0,1,0,1 -> data_o=8'hA5 and valid_o=1 on the 8th edge; busy_o high during the 8 frame cycles; ack_i one cycle -> valid_o=0.
- MSB_FIRST=0, same bit sequence -> data_o=8'hA5 bit-reversed = 8'hA5 (palindrome). Repeat with 1,1,0,0,0,0,0,0 -> 8'h03.
- frame_i drops after 5 bits -> frame_err_o pulses once; valid_o stays 0; data_o unchanged; next full frame 8'h3C received correctly.
- Two frames 8'h11 then 8'h22 with no ack -> data_o=8'h22, valid_o=1, overrun_o=1 sticky. Repeat with ack_i asserted on the second commit edge -> overrun_o stays 0.
- frame_i held 12 cycles -> one commit of the first 8 bits; remaining 4 ignored; no error.
- rst asserted after 4 bits -> outputs return to reset values asynchronously. With S2P_PARITY_EN: 8'hA5 plus parity 0 -> parity_err_o=0; parity 1 -> parity_err_o=1.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package s2p_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECV     = 2'd1,
    ST_WAIT_END = 2'd2
  } s2p_state_e;

  // Bit counter width able to hold values 0..frame_len.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/s2p_shift_reg.sv
// Assembly shift register for the serial-to-parallel receiver.
// MSB_FIRST=1 shifts left inserting at bit 0; MSB_FIRST=0 shifts right inserting at the MSB.
// word_o shows the word including the current bit while shift_i is high, so the caller can
// commit on the same edge that samples the last bit.
module s2p_shift_reg #(
  parameter int unsigned DATA_SIZE = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic                 serial_i,
  output logic [DATA_SIZE-1:0] word_o
);

  logic [DATA_SIZE-1:0] sr_q, sr_d;
  logic [DATA_SIZE-1:0] shifted, loaded;

  // Candidate values for a shift into the current word or a fresh load of bit 0.
  always_comb begin
    shifted = sr_q;
    loaded  = '0;
    if (MSB_FIRST) begin
      shifted = {sr_q[DATA_SIZE-2:0], serial_i};
      loaded  = {{(DATA_SIZE-1){1'b0}}, serial_i};
    end else begin
      shifted = {serial_i, sr_q[DATA_SIZE-1:1]};
      loaded  = {serial_i, {(DATA_SIZE-1){1'b0}}};
    end
  end

  // Next-state select: clear beats load beats shift.
  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = loaded;
    end else if (shift_i) begin
      sr_d = shifted;
    end
  end

  // Shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Word as seen by the committing edge.
  always_comb begin
    word_o = shift_i ? shifted : sr_q;
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Framed serial-to-parallel receiver with valid/ack output handshake.
// Optional feature: define S2P_PARITY_EN to append an even-parity bit to each frame and
// expose parity_err_o.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_i,
  input  logic                 frame_i,
  input  logic                 ack_i,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 frame_err_o,
`ifdef S2P_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 overrun_o
);

`ifdef S2P_PARITY_EN
  localparam int unsigned FrameLen = DATA_SIZE + 1;
`else
  localparam int unsigned FrameLen = DATA_SIZE;
`endif
  localparam int unsigned CntW = cnt_width(FrameLen);
  localparam logic [CntW-1:0] LastIdx  = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] DataBits = CntW'(DATA_SIZE);

  s2p_state_e           state_q;
  logic [CntW-1:0]      cnt_q;
  logic [DATA_SIZE-1:0] data_q;
  logic                 valid_q, busy_q, frame_err_q, overrun_q;
`ifdef S2P_PARITY_EN
  logic                 parity_err_q;
`endif

  logic                 start, in_bit, commit, shift_en, clr;
  logic [DATA_SIZE-1:0] word;

  // Frame decode: start in IDLE, sample in RECV, commit on the final frame bit.
  always_comb begin
    start    = (state_q == ST_IDLE) && frame_i;
    in_bit   = (state_q == ST_RECV) && frame_i;
    commit   = in_bit && (cnt_q == LastIdx);
    // The parity bit (when present) is never shifted into the data word.
    shift_en = in_bit && (cnt_q < DataBits);
    clr      = (state_q == ST_RECV) && !frame_i;
  end

  s2p_shift_reg #(
    .DATA_SIZE (DATA_SIZE),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .load_i   (start),
    .shift_i  (shift_en),
    .serial_i (serial_i),
    .word_o   (word)
  );

  // FSM, bit counter and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;

      if (ack_i && valid_q) begin
        valid_q <= 1'b0;
      end
      // A commit overrides the ack clear; overrun only if the old word was never taken.
      if (commit) begin
        data_q  <= word;
        valid_q <= 1'b1;
        if (valid_q && !ack_i) begin
          overrun_q <= 1'b1;
        end
`ifdef S2P_PARITY_EN
        parity_err_q <= (^word) ^ serial_i;
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (frame_i) begin
            cnt_q   <= CntW'(1);
            state_q <= ST_RECV;
            busy_q  <= 1'b1;
          end
        end
        ST_RECV: begin
          if (frame_i) begin
            if (cnt_q == LastIdx) begin
              state_q <= ST_WAIT_END;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end
        end
        ST_WAIT_END: begin
          if (!frame_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign busy_o       = busy_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
`ifdef S2P_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: one MSB-first and one LSB-first instance share stimulus.
// Honours S2P_PARITY_EN by appending the parity bit to every full frame.
module tb_serial_to_parallel;

`ifdef S2P_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst, serial, frame, ack;
  logic [7:0] m_data, l_data;
  logic       m_valid, m_busy, m_ferr, m_ovr;
  logic       l_valid, l_busy, l_ferr, l_ovr;
`ifdef S2P_PARITY_EN
  logic       m_perr, l_perr;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int busy_cnt, ferr_cnt;

  always #5 clk = ~clk;

  serial_to_parallel #(.DATA_SIZE(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk          (clk),
    .rst          (rst),
    .serial_i     (serial),
    .frame_i      (frame),
    .ack_i        (ack),
    .data_o       (m_data),
    .valid_o      (m_valid),
    .busy_o       (m_busy),
    .frame_err_o  (m_ferr),
`ifdef S2P_PARITY_EN
    .parity_err_o (m_perr),
`endif
    .overrun_o    (m_ovr)
  );

  serial_to_parallel #(.DATA_SIZE(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .serial_i     (serial),
    .frame_i      (frame),
    .ack_i        (ack),
    .data_o       (l_data),
    .valid_o      (l_valid),
    .busy_o       (l_busy),
    .frame_err_o  (l_ferr),
`ifdef S2P_PARITY_EN
    .parity_err_o (l_perr),
`endif
    .overrun_o    (l_ovr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Send nbits framed bits; seq[7] goes first. Bit 8 is the parity bit when enabled,
  // further bits are filler ones. ack_last raises ack on the frame's final (commit) bit.
  task automatic send_frame(input logic [7:0] seq, input int nbits, input bit par_flip,
                            input bit ack_last);
    busy_cnt = 0;
    ferr_cnt = 0;
    for (int i = 0; i < nbits; i++) begin
      frame = 1'b1;
      if (i < 8) serial = seq[7-i];
      else if (i == 8 && FL == 9) serial = (^seq) ^ par_flip;
      else serial = 1'b1;
      ack = ack_last && (i == FL - 1);
      cyc();
      if (m_busy) busy_cnt++;
      if (m_ferr) ferr_cnt++;
    end
    frame  = 1'b0;
    serial = 1'b0;
    ack    = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; serial = 1'b0; frame = 1'b0; ack = 1'b0;
    repeat (2) cyc();
    check_val("rst_data", m_data, 8'h00);
    check_val("rst_data_lsb", l_data, 8'h00);
    check_val("rst_valid", m_valid, 1'b0);
    check_val("rst_busy", m_busy, 1'b0);
    check_val("rst_ferr", m_ferr, 1'b0);
    check_val("rst_ovr", m_ovr, 1'b0);
    rst = 1'b0;
    cyc();

    // Basic frame A5.
    send_frame(8'hA5, FL, 1'b0, 1'b0);
    check_val("a5_data", m_data, 8'hA5);
    check_val("a5_data_lsb", l_data, 8'hA5);
    check_val("a5_valid", m_valid, 1'b1);
    check_val("a5_busy_end", m_busy, 1'b0);
    check_val("a5_busy_cycles", busy_cnt, FL - 1);
    cyc();
    check_val("a5_valid_hold", m_valid, 1'b1);
    do_ack();
    check_val("a5_ack_valid", m_valid, 1'b0);
    check_val("a5_ack_data", m_data, 8'hA5);

    // Asymmetric pattern shows bit order.
    send_frame(8'hC0, FL, 1'b0, 1'b0);
    check_val("c0_data_msb", m_data, 8'hC0);
    check_val("c0_data_lsb", l_data, 8'h03);
    cyc();
    do_ack();
    check_val("c0_ack_valid_lsb", l_valid, 1'b0);

    // Short frame of 5 bits.
    send_frame(8'hF8, 5, 1'b0, 1'b0);
    check_val("short_ferr_early", ferr_cnt, 0);
    cyc();
    check_val("short_ferr", m_ferr, 1'b1);
    check_val("short_valid", m_valid, 1'b0);
    check_val("short_data", m_data, 8'hC0);
    check_val("short_data_lsb", l_data, 8'h03);
    check_val("short_busy", m_busy, 1'b0);
    cyc();
    check_val("short_ferr_pulse", m_ferr, 1'b0);
    send_frame(8'h3C, FL, 1'b0, 1'b0);
    check_val("after_short_data", m_data, 8'h3C);
    check_val("after_short_valid", m_valid, 1'b1);
    cyc();
    do_ack();

    // Overrun: two commits without ack.
    send_frame(8'h11, FL, 1'b0, 1'b0);
    cyc();
    check_val("ovr_not_yet", m_ovr, 1'b0);
    send_frame(8'h22, FL, 1'b0, 1'b0);
    check_val("ovr_data", m_data, 8'h22);
    check_val("ovr_data_lsb", l_data, 8'h44);
    check_val("ovr_valid", m_valid, 1'b1);
    check_val("ovr_flag", m_ovr, 1'b1);
    cyc();
    do_ack();
    check_val("ovr_ack_valid", m_valid, 1'b0);
    check_val("ovr_sticky", m_ovr, 1'b1);
    rst = 1'b1;
    #2;
    check_val("ovr_rst_clear", m_ovr, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    // Second commit coincides with ack: no overrun.
    send_frame(8'h11, FL, 1'b0, 1'b0);
    cyc();
    send_frame(8'h22, FL, 1'b0, 1'b1);
    check_val("ackcommit_data", m_data, 8'h22);
    check_val("ackcommit_valid", m_valid, 1'b1);
    check_val("ackcommit_ovr", m_ovr, 1'b0);
    cyc();
    do_ack();

    // Frame held 4 bits too long.
    send_frame(8'h96, FL + 4, 1'b0, 1'b0);
    check_val("long_data", m_data, 8'h96);
    check_val("long_data_lsb", l_data, 8'h69);
    check_val("long_valid", m_valid, 1'b1);
    check_val("long_ferr", ferr_cnt, 0);
    check_val("long_busy_cycles", busy_cnt, FL - 1);
    cyc();
    check_val("long_ferr_end", m_ferr, 1'b0);

    // Reset after 4 bits of a new frame (valid still pending from previous word).
    for (int i = 0; i < 4; i++) begin
      frame  = 1'b1;
      serial = 1'b1;
      cyc();
    end
    check_val("mid_busy", m_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_data", m_data, 8'h00);
    check_val("mid_rst_data_lsb", l_data, 8'h00);
    check_val("mid_rst_valid", m_valid, 1'b0);
    check_val("mid_rst_busy", m_busy, 1'b0);
    check_val("mid_rst_ovr", m_ovr, 1'b0);
    // Release with frame still high: next edge is bit 0 of a new frame.
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'hA5, FL, 1'b0, 1'b0);
    check_val("post_rst_data", m_data, 8'hA5);
    check_val("post_rst_valid", m_valid, 1'b1);
    cyc();
    do_ack();

`ifdef S2P_PARITY_EN
    send_frame(8'hA5, FL, 1'b0, 1'b0);
    check_val("par_ok_data", m_data, 8'hA5);
    check_val("par_ok_err", m_perr, 1'b0);
    cyc();
    do_ack();
    send_frame(8'hA5, FL, 1'b1, 1'b0);
    check_val("par_bad_data", m_data, 8'hA5);
    check_val("par_bad_valid", m_valid, 1'b1);
    check_val("par_bad_err", m_perr, 1'b1);
    check_val("par_bad_err_lsb", l_perr, 1'b1);
    cyc();
    do_ack();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
